// File: rtl/atari7800_pkg.sv
// Shared Atari 7800 core definitions: high-score upload FSM states and the open-bus fill byte.
package atari7800_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQuiesce,
    StReady,
    StFetch,
    StLatch
  } hs_state_e;

  localparam logic [7:0] FillByte = 8'hFF;

endpackage

// File: rtl/hiscore_upload.sv
// Serves the High Score Cart save SRAM to the HPS during an upload session and
// raises an autosave request once the core has stopped writing for a while.
module hiscore_upload
  import atari7800_pkg::*;
#(
  parameter int unsigned SAVE_BYTES  = 2048,
  parameter int unsigned IDLE_FRAMES = 120
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        save_en,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  input  logic        vsync,
  input  logic        core_sram_we,
  output logic [10:0] sram_addr,
  output logic        sram_rd,
  input  logic [7:0]  sram_q,
  output logic        hold,
  output logic        dirty,
  output logic        upload_req
);

  localparam int unsigned   CntW     = $clog2(IDLE_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(IDLE_FRAMES);
  localparam logic [24:0]   SaveLim  = 25'(SAVE_BYTES);

  hs_state_e       r_state, w_state_next;
  logic            r_qcnt;
  logic            r_upload_q, r_vsync_q;
  logic            r_upload_blk;
  logic            r_sram_rd;
  logic [10:0]     r_sram_addr;
  logic [7:0]      r_din;
  logic            r_dirty, r_armed, r_upload_req;
  logic [CntW-1:0] r_cnt, w_cnt_next;

  logic w_up_rise, w_up_fall, w_vs_rise;
  logic w_start_rd, w_oob_rd, w_latch, w_fill_idle;
  logic w_done, w_core_wr, w_fire;

  // A level still high out of reset is blocked until it has been seen low once.
  assign w_up_rise   = ioctl_upload & ~r_upload_q & ~r_upload_blk;
  assign w_up_fall   = ~ioctl_upload & r_upload_q;
  assign w_vs_rise   = vsync & ~r_vsync_q;
  assign w_done      = w_up_fall & (r_state != StIdle);
  assign w_core_wr   = core_sram_we & save_en & (r_state == StIdle);
  assign w_latch     = (r_state == StLatch) & (w_state_next == StReady);
  assign w_fill_idle = (r_state == StIdle) & w_up_rise & ~save_en;

  always_comb begin
    w_state_next = r_state;
    w_start_rd   = 1'b0;
    w_oob_rd     = 1'b0;
    unique case (r_state)
      StIdle:    if (w_up_rise && save_en) w_state_next = StQuiesce;
      StQuiesce: if (r_qcnt) w_state_next = StReady;
      StReady: begin
        if (ioctl_rd) begin
          if (ioctl_addr < SaveLim) begin
            w_start_rd   = 1'b1;
            w_state_next = StFetch;
          end else begin
            w_oob_rd = 1'b1;
          end
        end
      end
      StFetch:   w_state_next = StLatch;
      StLatch:   w_state_next = StReady;
      default:   w_state_next = StIdle;
    endcase
    // Session end overrides everything and aborts a read in flight.
    if (w_done) begin
      w_state_next = StIdle;
      w_start_rd   = 1'b0;
      w_oob_rd     = 1'b0;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_core_wr || w_done) begin
      w_cnt_next = '0;
    end else if (r_dirty && r_armed && w_vs_rise && (r_cnt < CntMax)) begin
      w_cnt_next = r_cnt + CntW'(1);
    end
    w_fire = ~w_core_wr & ~w_done & r_dirty & r_armed & ~ioctl_upload & (w_cnt_next == CntMax);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= StIdle;
      r_qcnt       <= 1'b0;
      r_upload_q   <= 1'b0;
      r_vsync_q    <= 1'b0;
      r_upload_blk <= 1'b1;
      r_sram_rd    <= 1'b0;
      r_sram_addr  <= '0;
      r_din        <= 8'h00;
      r_dirty      <= 1'b0;
      r_armed      <= 1'b1;
      r_cnt        <= '0;
      r_upload_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_qcnt     <= (r_state == StQuiesce) && (w_state_next == StQuiesce);
      r_upload_q <= ioctl_upload;
      r_vsync_q  <= vsync;
      if (!ioctl_upload) r_upload_blk <= 1'b0;
      r_sram_rd <= w_start_rd;
      if (w_start_rd) r_sram_addr <= ioctl_addr[10:0];
      if (w_latch) begin
        r_din <= sram_q;
      end else if (w_oob_rd || w_fill_idle) begin
        r_din <= FillByte;
      end
      r_cnt        <= w_cnt_next;
      r_upload_req <= w_fire;
      if (w_core_wr) begin
        r_dirty <= 1'b1;
        r_armed <= 1'b1;
      end else if (w_done) begin
        r_dirty <= 1'b0;
      end else if (w_fire) begin
        r_armed <= 1'b0;
      end
    end
  end

  assign hold       = (r_state != StIdle);
  assign sram_rd    = r_sram_rd;
  assign sram_addr  = r_sram_addr;
  assign ioctl_din  = r_din;
  assign dirty      = r_dirty;
  assign upload_req = r_upload_req & ~ioctl_upload;

endmodule

// File: tb/tb_hiscore_upload.sv
// Self-checking bench for hiscore_upload: read-vector table, directed autosave and
// reset corners, and randomized frame/write traffic against a frame-count model.
module tb_hiscore_upload;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        save_en = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        vsync = 1'b0;
  logic        core_sram_we = 1'b0;
  logic [10:0] sram_addr;
  logic        sram_rd;
  logic [7:0]  sram_q = 8'h00;
  logic        hold;
  logic        dirty;
  logic        upload_req;

  logic [7:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  hiscore_upload dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .save_en      (save_en),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .vsync        (vsync),
    .core_sram_we (core_sram_we),
    .sram_addr    (sram_addr),
    .sram_rd      (sram_rd),
    .sram_q       (sram_q),
    .hold         (hold),
    .dirty        (dirty),
    .upload_req   (upload_req)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (sram_rd) sram_q <= mem[sram_addr];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp_din;
    bit          in_range;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives n vsync pulses (1 high, 2 low) and reports upload_req pulses seen.
  task automatic vs_pulses(input int n, output int pulses, output int last_idx);
    pulses   = 0;
    last_idx = 0;
    for (int k = 1; k <= n; k++) begin
      vsync = 1'b1;
      tick();
      if (upload_req) begin
        pulses++;
        last_idx = k;
      end
      vsync = 1'b0;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (upload_req) pulses++;
      end
    end
  endtask

  task automatic start_session();
    ioctl_upload = 1'b1;
    tick();
    tick();
    tick();
  endtask

  int p, li;
  int m_frames;
  bit m_dirty, m_armed, m_prev_vs, m_req, m_rise;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h11;
    mem[5]    = 8'h3C;
    mem[0]    = 8'h5A;
    mem[1024] = 8'hC3;
    mem[2047] = 8'hA5;
    vecs[0] = '{addr: 25'd5,        exp_din: 8'h3C, in_range: 1'b1};
    vecs[1] = '{addr: 25'd2048,     exp_din: 8'hFF, in_range: 1'b0};
    vecs[2] = '{addr: 25'd2047,     exp_din: 8'hA5, in_range: 1'b1};
    vecs[3] = '{addr: 25'd0,        exp_din: 8'h5A, in_range: 1'b1};
    vecs[4] = '{addr: 25'h1FFFFFF,  exp_din: 8'hFF, in_range: 1'b0};
    vecs[5] = '{addr: 25'd1024,     exp_din: 8'hC3, in_range: 1'b1};

    // Reset values
    tick();
    tick();
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_sram_rd", 32'(sram_rd), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_dirty", 32'(dirty), 32'd0);
    check("rst_upload_req", 32'(upload_req), 32'd0);
    reset = 1'b0;
    tick();

    // No cart: session never starts, open-bus byte returned
    save_en = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    check("nocart_hold", 32'(hold), 32'd0);
    check("nocart_din", 32'(ioctl_din), 32'hFF);
    tick();
    check("nocart_hold2", 32'(hold), 32'd0);
    ioctl_upload = 1'b0;
    tick();

    // Session with read table
    save_en = 1'b1;
    ioctl_upload = 1'b1;
    tick();
    check("sess_hold", 32'(hold), 32'd1);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    tick();
    ioctl_rd = 1'b0;
    check("quiesce_rd_ignored", 32'(sram_rd), 32'd0);
    tick();
    core_sram_we = 1'b1;
    tick();
    core_sram_we = 1'b0;
    check("held_write_blocked", 32'(dirty), 32'd0);
    tick();
    for (int v = 0; v < 6; v++) begin
      ioctl_rd = 1'b1;
      ioctl_addr = vecs[v].addr;
      tick();
      ioctl_rd = 1'b0;
      if (vecs[v].in_range) begin
        check($sformatf("vec%0d_sram_rd", v), 32'(sram_rd), 32'd1);
        check($sformatf("vec%0d_sram_addr", v), 32'(sram_addr), 32'(vecs[v].addr[10:0]));
        tick();
        tick();
        check($sformatf("vec%0d_din", v), 32'(ioctl_din), 32'(vecs[v].exp_din));
        tick();
      end else begin
        check($sformatf("vec%0d_sram_rd", v), 32'(sram_rd), 32'd0);
        check($sformatf("vec%0d_din", v), 32'(ioctl_din), 32'(vecs[v].exp_din));
        tick();
        tick();
        tick();
      end
      check($sformatf("vec%0d_hold", v), 32'(hold), 32'd1);
    end
    ioctl_upload = 1'b0;
    tick();
    check("sess_end_hold", 32'(hold), 32'd0);

    // One write then 120 frames: single request on the 120th
    core_sram_we = 1'b1;
    tick();
    core_sram_we = 1'b0;
    check("write_dirty", 32'(dirty), 32'd1);
    vs_pulses(120, p, li);
    check("autosave_pulses", 32'(p), 32'd1);
    check("autosave_edge", 32'(li), 32'd120);
    vs_pulses(200, p, li);
    check("autosave_no_repeat", 32'(p), 32'd0);

    // Write coincident with the 119th frame restarts the count
    core_sram_we = 1'b1;
    tick();
    core_sram_we = 1'b0;
    vs_pulses(118, p, li);
    check("coinc_pre_pulses", 32'(p), 32'd0);
    vsync = 1'b1;
    core_sram_we = 1'b1;
    tick();
    check("coinc_no_req", 32'(upload_req), 32'd0);
    vsync = 1'b0;
    core_sram_we = 1'b0;
    tick();
    tick();
    vs_pulses(119, p, li);
    check("coinc_119_pulses", 32'(p), 32'd0);
    vs_pulses(1, p, li);
    check("coinc_120th_pulse", 32'(p), 32'd1);

    // Completed session clears dirty
    check("pre_sess_dirty", 32'(dirty), 32'd1);
    start_session();
    ioctl_upload = 1'b0;
    tick();
    check("sess_clears_dirty", 32'(dirty), 32'd0);

    // Reset mid-fetch with upload held high
    start_session();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    reset = 1'b1;
    tick();
    check("rstfetch_hold", 32'(hold), 32'd0);
    check("rstfetch_din", 32'(ioctl_din), 32'h00);
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rstfetch_no_restart", 32'(hold), 32'd0);
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    check("rstfetch_retoggle", 32'(hold), 32'd1);
    ioctl_upload = 1'b0;
    tick();
    check("rstfetch_end", 32'(hold), 32'd0);

    // Randomized writes/frames against a frames-since-last-write model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_frames  = 0;
    m_dirty   = 1'b0;
    m_armed   = 1'b1;
    m_prev_vs = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      core_sram_we = ($urandom_range(0, 899) == 0);
      vsync        = ($urandom_range(0, 2) == 0);
      save_en      = ($urandom_range(0, 9) != 0);
      m_rise = vsync && !m_prev_vs;
      m_req  = 1'b0;
      if (core_sram_we && save_en) begin
        m_dirty  = 1'b1;
        m_frames = 0;
        m_armed  = 1'b1;
      end else if (m_dirty && m_armed && m_rise) begin
        m_frames++;
        if (m_frames == 120) begin
          m_req   = 1'b1;
          m_armed = 1'b0;
        end
      end
      m_prev_vs = vsync;
      tick();
      check("rand_upload_req", 32'(upload_req), 32'(m_req));
      check("rand_dirty", 32'(dirty), 32'(m_dirty));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
